program_mem: RTL and testbench
==============================

PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter BOOT_LEN, default 18, number of boot-image words loaded by init; legal range 0..DEPTH.
REQ-004 clock  input  1  single clock; all state SHALL change on its rising edge except under reset.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 init_req  input  1  request to load the boot image; sampled on the clock edge.
REQ-007 init_busy  output  1  high while the loader owns the memory.
REQ-008 init_done  output  1  high once a load has completed; stays high until the next reset or load.
REQ-009 we  input  1  write enable.
REQ-010 re  input  1  read enable.
REQ-011 addr  input  ADDR_W  word address for read/write.
REQ-012 d  input  DATA_W  write data.
REQ-013 q  output  DATA_W  registered read data.
REQ-014 q_valid  output  1  one-cycle strobe qualifying q.
REQ-015 parity_err  output  1  read-parity error strobe; present only when PROGRAM_MEM_PARITY_EN is defined.

Function
REQ-016 Loader FSM states: IDLE, LOAD, DONE.
REQ-017 IDLE or DONE with init_req=1 SHALL go to LOAD with index=0, init_busy=1, init_done=0.
REQ-018 In LOAD, one word is written per cycle to address index, then index increments; after writing index DEPTH-1 the FSM SHALL enter DONE (init_busy=0, init_done=1). Load time is exactly DEPTH cycles.
REQ-019 Boot image words 0..17 (hex, zero-extended to DATA_W): 80 3E 80 3F 1E 7F B0 CC 1F 7E 3F C4 1E 7F 3E C4 1E FF; words at index >= BOOT_LEN, and words beyond 17, SHALL be loaded as 0.
REQ-020 init_req asserted during LOAD SHALL be ignored; the load is not restarted.
REQ-021 While init_busy=1, we and re SHALL be ignored: no write occurs and q_valid stays 0.
REQ-022 Outside LOAD, we=1 SHALL write d to mem[addr] at the clock edge.
REQ-023 Outside LOAD, re=1 with we=0 SHALL register mem[addr] into q and pulse q_valid=1 on the next cycle; the read latency is 1 cycle.
REQ-024 When re=1 and we=1 on the same cycle, the write SHALL occur and no read is performed (q unchanged, q_valid=0), preserving write priority.
REQ-025 q SHALL hold its last value when no read occurs; q_valid is high for exactly one cycle per accepted read.
REQ-026 Memory access outside LOAD SHALL be permitted whether or not init_done=1.

Reset
REQ-027 resetn=0 SHALL immediately force FSM=IDLE, index=0, init_busy=0, init_done=0, q=0, q_valid=0, parity_err=0.
REQ-028 Reset SHALL NOT clear the memory array; a load interrupted by reset leaves partially loaded contents, and init_done stays 0 until a full load completes.

Configuration
REQ-029 Macro PROGRAM_MEM_PARITY_EN defined: each word SHALL store an extra even-parity bit, computed on every write and load; a read whose stored parity mismatches SHALL pulse parity_err with q_valid. q still returns the stored data.
REQ-030 PROGRAM_MEM_PARITY_EN undefined: no parity storage and no parity_err port; all other behaviour is identical.

Verification
REQ-031 Reset, init_req pulse -> init_busy high 32 cycles, then init_done=1; reads of addr 0,6,17,18,31 -> q=80,B0,FF,00,00, each with q_valid one cycle after re.
REQ-032 After init, we=1 addr=5 d=A5, then re addr=5 -> q=A5 on the next cycle; re addr=4 -> q=1E.
REQ-033 we=1 and re=1 on the same cycle at addr 3, d=55 -> q_valid=0; a subsequent read of addr 3 -> 55.
REQ-034 we=1 addr=2 d=00 and re=1 during LOAD -> ignored; after DONE, a read of addr 2 -> 80; a second init_req mid-load does not extend the load beyond 32 cycles.
REQ-035 resetn low at LOAD index 10 -> outputs reset asynchronously, init_done=0; a new init_req completes in 32 cycles with the correct image.
REQ-036 With PROGRAM_MEM_PARITY_EN defined, force a stored parity bit flip at addr 1, then read -> q=3E, q_valid=1, parity_err=1; a clean address read -> parity_err=0.

Source files
------------

// File: rtl/program_mem.sv
// program_mem: word-addressed program memory with a boot-image loader FSM and 1-cycle registered reads.
// Defining PROGRAM_MEM_PARITY_EN adds a stored even-parity bit per word and the parity_err read strobe.
module program_mem #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int BOOT_LEN = 18
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_done,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
`ifdef PROGRAM_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              q_valid
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef PROGRAM_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;
`ifdef PROGRAM_MEM_PARITY_EN
    logic              parity_err_q;
`endif
    logic [MEM_W-1:0]  mem_q [DEPTH];

    logic              loading;
    logic              rd_fire;
    logic [MEM_W-1:0]  rd_word;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [MEM_W-1:0]  wr_word_d;

    // Boot image: the first 18 words are fixed; anything past BOOT_LEN or past word 17 is zero.
    function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] idx);
        int         i;
        logic [7:0] w;
        i = int'(idx);
        w = 8'h00;
        case (i)
            0:  w = 8'h80;
            1:  w = 8'h3E;
            2:  w = 8'h80;
            3:  w = 8'h3F;
            4:  w = 8'h1E;
            5:  w = 8'h7F;
            6:  w = 8'hB0;
            7:  w = 8'hCC;
            8:  w = 8'h1F;
            9:  w = 8'h7E;
            10: w = 8'h3F;
            11: w = 8'hC4;
            12: w = 8'h1E;
            13: w = 8'h7F;
            14: w = 8'h3E;
            15: w = 8'hC4;
            16: w = 8'h1E;
            17: w = 8'hFF;
            default: w = 8'h00;
        endcase
        if (i >= BOOT_LEN) w = 8'h00;
        return DATA_W'(w);
    endfunction

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] w);
`ifdef PROGRAM_MEM_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    assign loading = (state_q == LOAD);
    assign rd_fire = !loading && re && !we;
    assign rd_word = mem_q[addr];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = addr;
        wr_word_d = encode(d);
        if (loading) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_word_d = encode(boot_word(idx_q));
        end else if (we) begin
            wr_en_d   = 1'b1;
        end
    end

    // NOTE: the array has no reset on purpose; contents survive resetn, and a reset port would block RAM inference.
    always_ff @(posedge clock) begin
        if (wr_en_d) mem_q[wr_addr_d] <= wr_word_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (init_req) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (idx_q == IDX_LAST) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_q          <= '0;
            q_valid_q    <= 1'b0;
`ifdef PROGRAM_MEM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            q_valid_q <= rd_fire;
            if (rd_fire) q_q <= rd_word[DATA_W-1:0];
`ifdef PROGRAM_MEM_PARITY_EN
            parity_err_q <= rd_fire && (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`endif
        end
    end

    assign init_busy = busy_q;
    assign init_done = done_q;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
`ifdef PROGRAM_MEM_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_program_mem.sv
// Self-checking bench for program_mem: directed vector table, loader corner cases and a random
// read/write phase scored against an array model of the memory.
module tb_program_mem;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clock;
    logic              resetn;
    logic              init_req;
    logic              init_busy;
    logic              init_done;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;
    logic              q_valid;
`ifdef PROGRAM_MEM_PARITY_EN
    logic              parity_err;
`endif

    program_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BOOT_LEN(18)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .init_req  (init_req),
        .init_busy (init_busy),
        .init_done (init_done),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .d         (d),
        .q         (q),
`ifdef PROGRAM_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .q_valid   (q_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] boot_img [DEPTH];
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_q;

    typedef struct {
        logic       we;
        logic       re;
        logic [4:0] addr;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_qv;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulses init_req, then counts busy cycles; optionally pokes we/re/init_req mid-load.
    task automatic run_load(input bit inject);
        int cnt;
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("load_start_busy", init_busy, 1);
        check("load_start_done", init_done, 0);
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 100) begin
            if (inject && cnt == 5) begin
                we = 1'b1; re = 1'b1; addr = 5'd2; d = 8'h00; init_req = 1'b1;
                step();
                we = 1'b0; re = 1'b0; init_req = 1'b0;
                check("load_ignores_read", q_valid, 0);
            end else begin
                step();
            end
            cnt++;
        end
        check("load_cycles", cnt, 32);
        check("load_done", init_done, 1);
        check("load_busy_clear", init_busy, 0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = boot_img[i];
    endtask

    task automatic do_read(input string name, input logic [4:0] a, input logic [7:0] exp);
        re = 1'b1; we = 1'b0; addr = a;
        step();
        re = 1'b0;
        check({name, "_q"}, q, exp);
        check({name, "_qv"}, q_valid, 1);
        model_q = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        boot_img = '{8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hB0, 8'hCC,
                     8'h1F, 8'h7E, 8'h3F, 8'hC4, 8'h1E, 8'h7F, 8'h3E, 8'hC4,
                     8'h1E, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h80, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 5'd6,  8'h00, 8'hB0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 5'd17, 8'h00, 8'hFF, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 5'd18, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 5'd31, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 5'd2,  8'h00, 8'h80, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 5'd9,  8'h00, 8'h80, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd5,  8'hA5, 8'h80, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 5'd5,  8'h00, 8'hA5, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 5'd4,  8'h00, 8'h1E, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 5'd3,  8'h55, 8'h1E, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 5'd3,  8'h00, 8'h55, 1'b1};

        resetn = 1'b0; init_req = 1'b0; we = 1'b0; re = 1'b0; addr = '0; d = '0;
        #3;
        check("rst_busy", init_busy, 0);
        check("rst_done", init_done, 0);
        check("rst_q", q, 0);
        check("rst_qv", q_valid, 0);
        repeat (2) step();
        resetn = 1'b1;
        step();

        // Full load with a write/read/init_req poke in the middle of it.
        run_load(1'b1);

        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; d = vecs[i].d;
            step();
            we = 1'b0; re = 1'b0;
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_qv", i), q_valid, vecs[i].exp_qv);
            if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].d;
            model_q = vecs[i].exp_q;
        end

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            logic       exp_qv;
            logic       r_we;
            logic       r_re;
            logic [4:0] r_a;
            logic [7:0] r_d;
            r_we = ($urandom_range(0, 2) == 0);
            r_re = ($urandom_range(0, 1) == 1);
            r_a  = 5'($urandom_range(0, 31));
            r_d  = 8'($urandom);
            we = r_we; re = r_re; addr = r_a; d = r_d;
            exp_qv = r_re && !r_we;
            if (exp_qv) model_q = model_mem[r_a];
            if (r_we) model_mem[r_a] = r_d;
            step();
            we = 1'b0; re = 1'b0;
            check("rand_q", q, model_q);
            check("rand_qv", q_valid, exp_qv);
`ifdef PROGRAM_MEM_PARITY_EN
            check("rand_perr", parity_err, 0);
`endif
        end

        // Reload from DONE, then reset asynchronously with index at 10.
        begin
            logic [7:0] keep25;
            keep25 = model_mem[25];
            init_req = 1'b1;
            step();
            init_req = 1'b0;
            check("reload_busy", init_busy, 1);
            check("reload_done_low", init_done, 0);
            repeat (10) step();
            #2;
            resetn = 1'b0;
            #1;
            check("async_rst_busy", init_busy, 0);
            check("async_rst_done", init_done, 0);
            check("async_rst_q", q, 0);
            check("async_rst_qv", q_valid, 0);
            step();
            resetn = 1'b1;
            step();
            step();
            check("post_rst_done", init_done, 0);
            model_q = 8'h00;
            do_read("partial_idx5", 5'd5, boot_img[5]);
            do_read("partial_idx25", 5'd25, keep25);
        end

        run_load(1'b0);
        for (int i = 0; i < DEPTH; i++) do_read($sformatf("image%0d", i), 5'(i), boot_img[i]);

`ifdef PROGRAM_MEM_PARITY_EN
        dut.mem_q[1][DATA_W] = ~dut.mem_q[1][DATA_W];
        re = 1'b1; addr = 5'd1;
        step();
        re = 1'b0;
        check("perr_q", q, 8'h3E);
        check("perr_qv", q_valid, 1);
        check("perr_flag", parity_err, 1);
        re = 1'b1; addr = 5'd0;
        step();
        re = 1'b0;
        check("perr_clean_q", q, 8'h80);
        check("perr_clean_flag", parity_err, 0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
